// File: rtl/hazard_ctrl_pn.sv
// Pipeline hazard controller: per-latch enable/flush vectors, load-use bubbles,
// EX/MEM bypass selects, sticky halt and dmem stall watchdog. Optional perf counters: HAZARD_PERF_EN.
module hazard_ctrl_pn #(
   parameter int unsigned NLATCH    = 4,
   parameter int unsigned MEM_LATCH = 2,
   parameter int unsigned REGW      = 5,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              ihit,
   input  logic              dhit,
   input  logic              dmemREN,
   input  logic              dmemWEN,
   input  logic [REGW-1:0]   id_rs,
   input  logic [REGW-1:0]   id_rt,
   input  logic [REGW-1:0]   ex_rd,
   input  logic              ex_regWEN,
   input  logic              ex_memREN,
   input  logic [REGW-1:0]   mem_rd,
   input  logic              mem_regWEN,
   input  logic              mem_branch_taken,
   input  logic              wb_halt,
   output logic [NLATCH-1:0] stage_en,
   output logic [NLATCH-1:0] stage_flush,
   output logic              pcen,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              halted,
   output logic              mem_timeout
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       flush_events,
   output logic [31:0]       ldu_bubbles
`endif
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_TOP  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_TRIP = CNT_W'(TIMEOUT - 1);
   localparam logic [NLATCH-1:0] LAST_LATCH = {1'b1, {(NLATCH-1){1'b0}}};
   // Latches 0..MEM_LATCH hold younger, wrong-path instructions on a taken branch.
   localparam logic [NLATCH-1:0] BR_FLUSH =
      NLATCH'((65'(1) << (MEM_LATCH + 1)) - 65'(1));

   typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               to_q, to_d;
   logic               mem_stall;
   logic               load_use;
   logic               running;

   assign running   = (state_q == ST_RUN);
   assign mem_stall = (dmemREN | dmemWEN) & ~dhit;
   assign load_use  = ex_memREN & ex_regWEN & (ex_rd != '0) &
                      ((ex_rd == id_rs) | (ex_rd == id_rt));

   // EX result wins over MEM; a load in EX has no result yet.
   function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] src);
      if (ex_regWEN && (ex_rd != '0) && (ex_rd == src) && !ex_memREN)
         return 2'd1;
      else if (mem_regWEN && (mem_rd != '0) && (mem_rd == src))
         return 2'd2;
      else
         return 2'd0;
   endfunction

   // State register
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
      end
   end

   // Next state and watchdog
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      if (running && wb_halt)
         state_d = ST_HALT;
      if (!mem_stall) begin
         cnt_d = '0;
      end else if (running) begin
         if (cnt_q != CNT_TOP)
            cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_TRIP)
            to_d = 1'b1;
      end
   end

   // Outputs, priority-ordered hazard resolution
   always_comb begin
      stage_en    = '0;
      stage_flush = '0;
      pcen        = 1'b0;
      fwd_a       = 2'd0;
      fwd_b       = 2'd0;
      if (!nRST) begin
         stage_flush = '1;
      end else if (running) begin
         fwd_a = fwd_sel(id_rs);
         fwd_b = fwd_sel(id_rt);
         if (mem_stall) begin
            stage_en    = LAST_LATCH;
            stage_flush = LAST_LATCH;
         end else if (mem_branch_taken) begin
            stage_en    = '1;
            stage_flush = BR_FLUSH;
            pcen        = 1'b1;
         end else if (load_use) begin
            stage_en    = ~NLATCH'(1);
            stage_flush = NLATCH'(2);
         end else if (!ihit) begin
            stage_en    = '1;
            stage_flush = NLATCH'(1);
         end else begin
            stage_en    = '1;
            pcen        = 1'b1;
         end
      end
   end

   assign halted      = (state_q == ST_HALT);
   assign mem_timeout = to_q;

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_q, flush_q, ldu_q;
   logic        ldu_sel;

   assign ldu_sel = ~mem_stall & ~mem_branch_taken & load_use;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         stall_q <= '0;
         flush_q <= '0;
         ldu_q   <= '0;
      end else if (running) begin
         if (mem_stall | ~ihit)
            stall_q <= stall_q + 32'd1;
         if (mem_branch_taken)
            flush_q <= flush_q + 32'd1;
         if (ldu_sel)
            ldu_q <= ldu_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_events = flush_q;
   assign ldu_bubbles  = ldu_q;
`endif

endmodule

// File: doc/hazard_ctrl_pn.md
Name: hazard_ctrl_pN

Overview:
Parametrised pipeline hazard controller for the pipelined MIPS datapath. It drives per-latch enable and flush vectors for an NLATCH-deep pipeline from a single block. It replaces fixed per-latch signals with vectors and adds:
- load-use bubble insertion
- EX/MEM→ID bypass selection
- a sticky halt state
- a data-memory stall watchdog

It sits beside the datapath and is fed by the decode, EX, MEM and WB latch outputs and the cache hit lines.

Parameters:
NLATCH, 4, number of pipeline latches; latch k sits after stage k (0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB).
MEM_LATCH, 2, index of the latch feeding the memory stage; branches resolve in that stage.
REGW, 5, register index width.
TIMEOUT, 1024, dmem stall cycles before mem_timeout is raised; must be ≥2.

Ports:
CLK  in  1  clock, rising edge.
nRST  in  1  synchronous active-low reset.
ihit  in  1  instruction fetch complete.
dhit  in  1  data access complete.
dmemREN  in  1  memory stage read request.
dmemWEN  in  1  memory stage write request.
id_rs  in  REGW  ID source register.
id_rt  in  REGW  ID target register.
ex_rd  in  REGW  EX destination.
ex_regWEN  in  1  EX writes a register.
ex_memREN  in  1  EX instruction is a load.
mem_rd  in  REGW  MEM destination.
mem_regWEN  in  1  MEM writes a register.
mem_branch_taken  in  1  branch/jump in MEM redirects the PC.
wb_halt  in  1  halt instruction is in WB.
stage_en  out  NLATCH  per-latch load enable.
stage_flush  out  NLATCH  per-latch bubble insert (a flush on a latch whose enable is 1 loads a NOP).
pcen  out  1  PC update enable.
fwd_a  out  2  rs bypass select: 0=regfile, 1=EX/MEM result, 2=MEM/WB result.
fwd_b  out  2  rt bypass select, same encoding.
halted  out  1  sticky halt indication.
mem_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (nRST=0 at a rising edge):
  - state←RUN; stall counter←0; halted←0; mem_timeout←0.
  - While nRST=0, outputs are forced to: stage_en=0, stage_flush=all 1s, pcen=0, fwd_a=fwd_b=0.
- States:
  - RUN.
  - HALTED. RUN→HALTED on the edge where wb_halt=1. HALTED is left only by reset.
- In HALTED: stage_en=0, stage_flush=0, pcen=0, halted=1.
- In RUN, conditions are evaluated combinationally each cycle in priority order; the first match wins.
  1. mem_stall = (dmemREN|dmemWEN) & ~dhit:
     - stage_en=0 for all latches except latch NLATCH-1.
     - stage_en[NLATCH-1]=1 and stage_flush[NLATCH-1]=1 (bubble into WB).
     - pcen=0.
  2. mem_branch_taken:
     - pcen=1; all stage_en=1.
     - stage_flush[k]=1 for k=0..MEM_LATCH; other flushes are 0.
     - Applied regardless of ihit (the abandoned fetch is discarded).
  3. load_use = ex_memREN & ex_regWEN & ex_rd≠0 & (ex_rd==id_rs | ex_rd==id_rt):
     - pcen=0; stage_en[0]=0; stage_flush[1]=1.
     - All other latches are enabled.
     - Exactly one bubble is inserted, because the load advances to MEM on the next edge.
  4. ~ihit:
     - pcen=0; stage_en[0]=1 with stage_flush[0]=1.
     - All other latches advance.
  5. Otherwise: all stage_en=1, all stage_flush=0, pcen=1.
- Bypass (fwd_a shown; fwd_b is identical with id_rt):
  - 1 if ex_regWEN & ex_rd≠0 & ex_rd==id_rs & ~ex_memREN.
  - Else 2 if mem_regWEN & mem_rd≠0 & mem_rd==id_rs.
  - Else 0.
  - EX has priority over MEM. fwd_a and fwd_b are 0 in HALTED.
- Watchdog:
  - Width is $clog2(TIMEOUT+1). The counter increments on each RUN edge with mem_stall=1 and clears on any edge with mem_stall=0.
  - When the counter equals TIMEOUT-1 and mem_stall=1, mem_timeout←1 (sticky until reset).
  - The counter saturates at TIMEOUT and does not wrap.
- Simultaneous events:
  - wb_halt with mem_stall: HALTED still entered.
  - Branch with load_use: the branch wins and the load-use bubble is dropped (the younger instructions are flushed anyway).
  - A reset edge mid-stall clears the counter and returns to RUN.

Optional Feature:
HAZARD_PERF_EN:
- When defined, adds 32-bit outputs stall_cycles, flush_events and ldu_bubbles.
  - stall_cycles increments on each RUN edge with mem_stall|~ihit.
  - flush_events increments on each RUN edge with a taken branch.
  - ldu_bubbles increments on each RUN edge where load_use is selected.
  - All three reset to 0 and wrap modulo 2^32.
- When undefined, these ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- Reset: hold nRST=0 for 2 cycles, then release → during reset stage_en=4'b0000, stage_flush=4'b1111, pcen=0; after the release edge state is RUN, halted=0, mem_timeout=0.
- Load-use: ex_memREN=1, ex_regWEN=1, ex_rd=5, id_rs=5, ihit=1, then ex_memREN=0 next cycle → cycle 1: pcen=0, stage_en=4'b1110, stage_flush=4'b0010; cycle 2: all enabled, no flush.
- Branch over fetch miss: mem_branch_taken=1, ihit=0 → pcen=1, stage_en=4'b1111, stage_flush=4'b0111.
- Dmem stall with TIMEOUT=4: dmemREN=1, dhit=0 held for 5 cycles → stage_en=4'b1000, stage_flush[3]=1 each cycle, mem_timeout rises after the 4th edge; dhit=1 → mem_timeout stays 1, counter cleared.
- Bypass: ex_rd=mem_rd=7, both regWEN=1, ex_memREN=0, id_rs=7, id_rt=0 → fwd_a=1, fwd_b=0; set ex_regWEN=0 → fwd_a=2.
- Halt: wb_halt=1 together with mem_stall → next cycle halted=1, pcen=0, stage_en=0; still halted after 10 cycles of ihit=dhit=1; a reset edge clears it.
